// File: rtl/mw_timer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : mw_timer_pkg                                            |
// | Description : Shared types and constants for the countdown timer:     |
// |               state encodings, command encodings, seconds limit and   |
// |               a binary-to-BCD helper for values 0..99.                |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package mw_timer_pkg;

   // Externally visible timer state (driven straight onto the state port)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // The single command that survives priority resolution in a cycle
   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_START = 3'd1,
      CMD_ADD   = 3'd2,
      CMD_PAUSE = 3'd3,
      CMD_STOP  = 3'd4
   } cmd_e;

   // Largest legal seconds value
   localparam logic [5:0] SEC_MAX = 6'd59;

   // Binary 0..99 to {tens, units} BCD
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'(v / 7'd10);
      units = 4'(v % 7'd10);
      return {tens, units};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tick_gen                                                |
// | Description : Seconds divider. Counts 0..TICK_DIV-1 while enabled and |
// |               emits a one-cycle enable pulse on the last count. Holds |
// |               its value while disabled; clr forces it back to zero.   |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   logic [c_cnt_w-1:0] cnt_q;
   logic [c_cnt_w-1:0] cnt_d;
   logic               at_last;

   assign at_last = (cnt_q == c_last);
   assign tick    = en && !clr && at_last;

   // Next divider value: clear wins, otherwise wrap-increment only when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_last ? '0 : (cnt_q + c_one);
      end
   end

   // Divider register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mw_timer_param.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : mw_timer_param                                          |
// | Description : Minutes/seconds countdown timer with start, stop,       |
// |               pause-toggle and add-time commands, clamped preset      |
// |               loading, saturating add and registered BCD display.     |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module mw_timer_param #(
   parameter int TICK_DIV = 100_000_000,
   parameter int MAX_MIN  = 99,
   parameter int ADD_SEC  = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       add,
   input  logic [6:0] min_in,
   input  logic [6:0] sec_in,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] state,
   output logic       done
);

   import mw_timer_pkg::*;

   // Elaboration-time parameter legality checks
   generate
      if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max_min
         $error("mw_timer_param: MAX_MIN must be in 1..99");
      end
      if (TICK_DIV < 2) begin : g_bad_tick_div
         $error("mw_timer_param: TICK_DIV must be 2 or more");
      end
      if (ADD_SEC < 1 || ADD_SEC > 59) begin : g_bad_add_sec
         $error("mw_timer_param: ADD_SEC must be in 1..59");
      end
   endgenerate

   localparam logic [6:0] c_max_min = 7'(MAX_MIN);
   localparam logic [5:0] c_add_sec = 6'(ADD_SEC);

   state_e     state_q, state_d;
   logic [6:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       done_q, done_d;
   logic [7:0] min_bcd_q, min_bcd_d;
   logic [7:0] sec_bcd_q, sec_bcd_d;

   cmd_e       cmd;
   logic [6:0] min_clamp;
   logic [5:0] sec_clamp;
   logic [6:0] sec_sum;
   logic [6:0] add_min;
   logic [5:0] add_sec;
   logic [6:0] dec_min;
   logic [5:0] dec_sec;
   logic       dec_zero;
   logic       tick;
   logic       div_en;
   logic       div_clr;

   // Clamp the preset inputs to the legal display range
   always_comb begin
      min_clamp = (min_in > c_max_min) ? c_max_min : min_in;
      sec_clamp = (sec_in > {1'b0, SEC_MAX}) ? SEC_MAX : sec_in[5:0];
   end

   // Resolve simultaneous commands: stop > pause > add > start
   always_comb begin
      cmd = CMD_NONE;
      if (stop) begin
         cmd = CMD_STOP;
      end else if (pause) begin
         cmd = CMD_PAUSE;
      end else if (add) begin
         cmd = CMD_ADD;
      end else if (start) begin
         cmd = CMD_START;
      end
   end

   // Count + ADD_SEC with carry into minutes, saturating at MAX_MIN:59
   always_comb begin
      sec_sum = {1'b0, sec_q} + {1'b0, c_add_sec};
      add_min = min_q;
      add_sec = sec_sum[5:0];
      if (sec_sum > {1'b0, SEC_MAX}) begin
         add_sec = 6'(sec_sum - 7'd60);
         add_min = min_q + 7'd1;
      end
      if (add_min > c_max_min) begin
         add_min = c_max_min;
         add_sec = SEC_MAX;
      end
   end

   // Count - 1 second with borrow from minutes; flag arrival at 0:00
   always_comb begin
      dec_min = min_q;
      dec_sec = sec_q - 6'd1;
      if (sec_q == 6'd0) begin
         dec_min = min_q - 7'd1;
         dec_sec = SEC_MAX;
      end
      dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);
   end

   // The divider only advances while the timer stays in RUN; a stop or
   // pause leaves it frozen where it was so a resumed run keeps its phase.
   assign div_en = (state_q == RUN) && (cmd != CMD_STOP) && (cmd != CMD_PAUSE);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clock (clock),
      .reset (reset),
      .en    (div_en),
      .clr   (div_clr),
      .tick  (tick)
   );

   // Next state, next count and done pulse. A command that takes effect
   // pre-empts the tick; start in RUN has no effect, so the tick proceeds.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      done_d  = 1'b0;
      div_clr = 1'b0;
      case (state_q)
         IDLE: begin
            min_d = min_clamp;
            sec_d = sec_clamp;
            if (cmd == CMD_START) begin
               state_d = RUN;
               div_clr = 1'b1;
               if ((min_clamp == 7'd0) && (sec_clamp == 6'd0)) begin
                  min_d = 7'd0;
                  sec_d = c_add_sec;
               end
            end
         end
         RUN: begin
            case (cmd)
               CMD_STOP:  state_d = IDLE;
               CMD_PAUSE: state_d = PAUSE;
               CMD_ADD: begin
                  min_d = add_min;
                  sec_d = add_sec;
               end
               default: begin
                  if (tick) begin
                     min_d = dec_min;
                     sec_d = dec_sec;
                     if (dec_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            endcase
         end
         PAUSE: begin
            case (cmd)
               CMD_STOP:  state_d = IDLE;
               CMD_PAUSE: state_d = RUN;
               CMD_START: state_d = RUN;
               CMD_ADD: begin
                  min_d = add_min;
                  sec_d = add_sec;
               end
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // Display registers track the count one cycle behind
   always_comb begin
      min_bcd_d = to_bcd(min_q);
      sec_bcd_d = to_bcd({1'b0, sec_q});
   end

   // State, count, done and display registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         min_q     <= 7'd0;
         sec_q     <= 6'd0;
         done_q    <= 1'b0;
         min_bcd_q <= 8'h00;
         sec_bcd_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         done_q    <= done_d;
         min_bcd_q <= min_bcd_d;
         sec_bcd_q <= sec_bcd_d;
      end
   end

   assign state   = state_q;
   assign done    = done_q;
   assign min_bcd = min_bcd_q;
   assign sec_bcd = sec_bcd_q;

endmodule
`default_nettype wire

// File: doc/mw_timer_param.md
MW_TIMER_PARAM -- requirements
Module: mw_timer_param

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, clock cycles per countdown second (legal range 2 or more).
REQ-002 SHALL have parameter MAX_MIN, default 99, maximum minutes value (legal range 1..99); an illegal value SHALL fail elaboration.
REQ-003 SHALL have parameter ADD_SEC, default 30, seconds added by quick-start and add (legal range 1..59).
REQ-004 SHALL have port clock, input, 1 bit: single clock domain for all logic.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle command pulse.
REQ-007 SHALL have port stop, input, 1 bit: single-cycle command pulse.
REQ-008 SHALL have port pause, input, 1 bit: single-cycle command pulse (toggles pause).
REQ-009 SHALL have port add, input, 1 bit: single-cycle command pulse (+ADD_SEC).
REQ-010 SHALL have port min_in, input, 7 bits: preset minutes, binary.
REQ-011 SHALL have port sec_in, input, 7 bits: preset seconds, binary.
REQ-012 SHALL have port min_bcd, output, 8 bits: remaining minutes as {tens, units} BCD.
REQ-013 SHALL have port sec_bcd, output, 8 bits: remaining seconds as {tens, units} BCD.
REQ-014 SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 PAUSE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on natural expiry.

Function
REQ-016 SHALL use a single clock: the seconds tick is an enable pulse from a divider, never a derived clock.
REQ-017 Divider SHALL count 0..TICK_DIV-1, pulse tick when at TICK_DIV-1 in RUN, clear on IDLE->RUN, and hold its value in PAUSE and IDLE.
REQ-018 In IDLE, the count SHALL load from the inputs every cycle with clamping: min>MAX_MIN loads MAX_MIN; sec>59 loads 59.
REQ-019 IDLE + start with a nonzero clamped count SHALL go to RUN.
REQ-020 IDLE + start with a clamped count of 0:00 SHALL load 0:ADD_SEC and go to RUN (quick-start).
REQ-021 On a RUN tick, the count SHALL decrement: if sec>0 then sec-1, else min-1 with sec=59.
REQ-022 The tick that makes the count 0:00 SHALL put the state in IDLE on the next edge, with done=1 for exactly that one cycle.
REQ-023 add in RUN/PAUSE SHALL add ADD_SEC to sec with carry into min, saturating at MAX_MIN:59; add in IDLE SHALL be ignored.
REQ-024 pause SHALL toggle RUN<->PAUSE; start in PAUSE SHALL go to RUN; start in RUN SHALL be ignored.
REQ-025 stop in RUN/PAUSE SHALL go to IDLE with done=0; the count then reloads per REQ-018.
REQ-026 Simultaneous commands SHALL resolve by priority stop > pause > add > start; lower-priority commands are dropped.
REQ-027 A command coinciding with a tick SHALL win, and that tick's decrement SHALL be skipped.
REQ-028 BCD outputs SHALL be registered and SHALL lag the internal count by exactly one cycle.

Reset
REQ-029 reset SHALL force state=IDLE, count=0:00, divider=0, min_bcd=sec_bcd=8'h00 and done=0, immediately and asynchronously.
REQ-030 reset asserted mid-run SHALL abort the run without any done pulse.

Structure
REQ-031 Package mw_timer_pkg SHALL hold the state encodings (IDLE, RUN, PAUSE) and the constant SEC_MAX=59.
REQ-032 The divider SHALL be sub-module tick_gen (params TICK_DIV; ports clock, reset, en, clr, tick).
REQ-033 Command pulses SHALL be produced upstream by edge detectors, outside this block.

Verification (TICK_DIV=4, MAX_MIN=99, ADD_SEC=30)
REQ-034 Preset 0:03, start -> sec_bcd 02,01,00 at 4-cycle intervals; done one cycle; state IDLE; no further decrement.
REQ-035 Preset 1:00, start -> after first tick min_bcd=00, sec_bcd=59.
REQ-036 RUN 0:10, pause after 2 divider cycles, wait 20 cycles, pause -> count frozen at 0:10; next tick 2 cycles after resume.
REQ-037 Preset 0:00, start -> RUN at 0:30; then preset 99:45, start, add -> 99:59 saturated.
REQ-038 IDLE with min_in=120, sec_in=75 -> min_bcd=99, sec_bcd=59.
REQ-039 RUN: stop and pause in the same cycle -> IDLE, done=0; then start, and reset mid-run -> IDLE, 00:00, done never 1.
